// File: rtl/bin_seq_gen.sv
// bin_seq_gen: small instruction sequencer that replays count/load/clear
// scripts on the control pins of an N-bit universal binary counter.
// Instruction word layout: {op[2:0], cnt[CW-1:0], data[N-1:0]}.
//
// Handshake note: there is no valid/ready pair here. start is a
// single-cycle request that is honoured only in IDLE. abort is honoured in
// any state and takes priority over start. done is a one-cycle
// acknowledgement of normal completion. busy is high whenever the FSM is
// outside IDLE.
module bin_seq_gen #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [3+CW+N-1:0] prog_data,
  input  logic            start,
  input  logic            abort,
  output logic            dut_rst,
  output logic            syn_clr,
  output logic            load,
  output logic            en,
  output logic            up,
  output logic [N-1:0]    d,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   pc,
  output logic [1:0]      dbg_state
);

  localparam int IW = 3 + CW + N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_WAIT = 3'd0,
    OP_UP   = 3'd1,
    OP_DN   = 3'd2,
    OP_LOAD = 3'd3,
    OP_SCLR = 3'd4,
    OP_RST  = 3'd5,
    OP_LOOP = 3'd6,
    OP_HALT = 3'd7
  } op_t;

  logic [IW-1:0] mem [DEPTH];

  state_t        state;
  op_t           ir_op;
  logic [CW-1:0] ir_cnt;
  logic [AW-1:0] ir_tgt;
  logic [CW-1:0] rem;
  logic          loop_act;
  logic [CW-1:0] lc;

  logic [2:0]    f_op;
  logic [CW-1:0] f_cnt;
  logic [N-1:0]  f_data;

  logic          multi_cycle;
  logic          last_pc;
  logic          loop_jump;
  logic          loop_act_nxt;
  logic [CW-1:0] lc_nxt;
  logic          jump;

  // Word at the current pc, split into its fields for the FETCH cycle.
  assign {f_op, f_cnt, f_data} = mem[pc];

  // Only WAIT/UP/DN honour the cycle count; every other op takes one cycle.
  assign multi_cycle = (ir_op == OP_WAIT) || (ir_op == OP_UP) || (ir_op == OP_DN);
  assign last_pc     = (pc == AW'(DEPTH - 1));
  assign jump        = (ir_op == OP_LOOP) && loop_jump;
  assign busy        = (state != S_IDLE);
  assign dbg_state   = state;

  // Program store: writes only land while idle so a running script is stable.
  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Loop decision for the LOOP instruction in EXEC; a single shared counter,
  // so a second LOOP met while one is active simply uses the same lc.
  always_comb begin
    loop_jump    = 1'b0;
    loop_act_nxt = loop_act;
    lc_nxt       = lc;
    if (!loop_act) begin
      if (ir_cnt != '0) begin
        loop_jump    = 1'b1;
        loop_act_nxt = 1'b1;
        lc_nxt       = ir_cnt - 1'b1;
      end
    end else if (lc == '0) begin
      loop_act_nxt = 1'b0;
    end else begin
      loop_jump = 1'b1;
      lc_nxt    = lc - 1'b1;
    end
  end

  // Sequencer FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir_op    <= OP_WAIT;
      ir_cnt   <= '0;
      ir_tgt   <= '0;
      rem      <= '0;
      loop_act <= 1'b0;
      lc       <= '0;
      dut_rst  <= 1'b0;
      syn_clr  <= 1'b0;
      load     <= 1'b0;
      en       <= 1'b0;
      up       <= 1'b0;
      d        <= '0;
      done     <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      loop_act <= 1'b0;
      lc       <= '0;
      dut_rst  <= 1'b0;
      syn_clr  <= 1'b0;
      load     <= 1'b0;
      en       <= 1'b0;
      up       <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          ir_op  <= op_t'(f_op);
          ir_cnt <= f_cnt;
          ir_tgt <= f_data[AW-1:0];
          rem    <= (f_cnt == '0) ? '0 : f_cnt - 1'b1;
          state  <= S_EXEC;
          case (op_t'(f_op))
            OP_UP: begin
              en <= 1'b1;
              up <= 1'b1;
            end
            OP_DN:   en      <= 1'b1;
            OP_LOAD: begin
              load <= 1'b1;
              d    <= f_data;
            end
            OP_SCLR: syn_clr <= 1'b1;
            OP_RST:  dut_rst <= 1'b1;
            default: ;
          endcase
        end

        S_EXEC: begin
          if (multi_cycle && rem != '0) begin
            rem <= rem - 1'b1;
          end else begin
            dut_rst <= 1'b0;
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b0;
            if (ir_op == OP_LOOP) begin
              loop_act <= loop_act_nxt;
              lc       <= lc_nxt;
            end
            if (jump) begin
              pc    <= ir_tgt;
              state <= S_FETCH;
            end else if (ir_op == OP_HALT || last_pc) begin
              // Explicit HALT, or running off the end of the store: pc is not wrapped.
              state    <= S_IDLE;
              done     <= 1'b1;
              loop_act <= 1'b0;
              lc       <= '0;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
